// File: rtl/cpu_defs_pkg.sv
// Shared CPU pipeline definitions: instruction/address widths, reset PC and fetch step.
// Imported by the fetch stage and by the reusable pipeline registers.
package cpu_defs_pkg;

    localparam int          INST_W       = 32;
    localparam int          DEF_ADDR_W   = 32;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          PC_STEP      = 4;

endpackage

// File: rtl/inst_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with flush, hold and bubble control (flush > hold > load > bubble).
// Optional macro FETCH_ALIGN_CHK_EN adds the address-error flag alongside the instruction.
module if_id_reg
    import cpu_defs_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0] inst_i,
`ifdef FETCH_ALIGN_CHK_EN
    input  logic              adel_i,
    output logic              adel_o,
`endif
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
`ifdef FETCH_ALIGN_CHK_EN
    logic              adel_q, adel_d;
`endif

    // Flush and bubble both leave a zeroed, invalid entry so downstream sees a clean NOP.
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
`ifdef FETCH_ALIGN_CHK_EN
        adel_d  = adel_q;
`endif
        if (flush_i || (!hold_i && !load_i)) begin
            pc_d    = '0;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            adel_d  = 1'b0;
`endif
        end else if (!hold_i) begin
            pc_d    = pc_i;
            inst_d  = inst_i;
            valid_d = 1'b1;
`ifdef FETCH_ALIGN_CHK_EN
            adel_d  = adel_i;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            adel_q  <= 1'b0;
`endif
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
`ifdef FETCH_ALIGN_CHK_EN
            adel_q  <= adel_d;
`endif
        end
    end

    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;
`ifdef FETCH_ALIGN_CHK_EN
    assign adel_o  = adel_q;
`endif

endmodule

// File: rtl/inst_fetch_stage.sv
// MIPS IF stage: owns the PC, drives the zero-latency instruction memory and fills IF/ID.
// Optional macro FETCH_ALIGN_CHK_EN flags misaligned fetches through id_adel_o.
module inst_fetch_stage
    import cpu_defs_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic [INST_W-1:0] inst_rdata_i,
    output logic              inst_ce_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
`ifdef FETCH_ALIGN_CHK_EN
    output logic              id_adel_o,
`endif
    output logic              id_valid_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic [INST_W-1:0] fetch_inst;

    // Branches redirect after the delay-slot word is fetched; stall ignores them since ID re-asserts.
    always_comb begin
        pc_d = pc_q;
        ce_d = 1'b1;
        if (flush_i) begin
            pc_d = flush_pc_i;
        end else if (!stall_i && ce_q) begin
            pc_d = branch_taken_i ? branch_target_i : pc_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
            ce_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            ce_q <= ce_d;
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    logic fetch_adel;
    assign fetch_adel = (pc_q[1:0] != 2'b00);
    assign fetch_inst = fetch_adel ? NOP_INST : inst_rdata_i;
`else
    assign fetch_inst = inst_rdata_i;
`endif

    assign inst_ce_o   = ce_q;
    assign inst_addr_o = pc_q;

    if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .hold_i  (stall_i),
        .load_i  (ce_q),
        .pc_i    (pc_q),
        .inst_i  (fetch_inst),
`ifdef FETCH_ALIGN_CHK_EN
        .adel_i  (fetch_adel),
        .adel_o  (id_adel_o),
`endif
        .pc_o    (id_pc_o),
        .inst_o  (id_inst_o),
        .valid_o (id_valid_o)
    );

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Scoreboard bench for inst_fetch_stage: directed fetch scenarios followed by random control traffic.
// A behavioural fetch model predicts the PC and IF/ID contents after every clock edge.
module tb_inst_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        branch_taken_i;
   logic [31:0] branch_target_i;
   logic [31:0] inst_rdata_i;
   logic        inst_ce_o;
   logic [31:0] inst_addr_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;
   logic        id_valid_o;
   logic        id_adel_o;

   typedef struct {
      logic        ce;
      logic [31:0] addr;
      logic [31:0] idPc;
      logic [31:0] idInst;
      logic        idValid;
      logic        idAdel;
   } expect_t;

   expect_t expQ[$];
   int assertCount = 0;
   int failCount = 0;

   logic [31:0] mPc;
   logic        mCe;
   logic [31:0] mIdPc;
   logic [31:0] mIdInst;
   logic        mIdValid;
   logic        mIdAdel;

   always #5 clk = ~clk;

   // Instruction memory contents: a few known words, a hash of the address elsewhere.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      logic [31:0] w;
      case (a)
         32'h0000_0000: w = 32'h0000f025;
         32'h0000_0004: w = 32'h241d1000;
         32'h0000_0008: w = 32'h8f990148;
         32'h0000_0020: w = 32'h10800003;
         32'h0000_00E0: w = 32'h00802025;
         default:       w = {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
      endcase
      return w;
   endfunction

   assign inst_rdata_i = memWord(inst_addr_o);

`ifndef FETCH_ALIGN_CHK_EN
   assign id_adel_o = 1'b0;
`endif

   inst_fetch_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .flush_pc_i      (flush_pc_i),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .inst_rdata_i    (inst_rdata_i),
      .inst_ce_o       (inst_ce_o),
      .inst_addr_o     (inst_addr_o),
      .id_pc_o         (id_pc_o),
      .id_inst_o       (id_inst_o),
`ifdef FETCH_ALIGN_CHK_EN
      .id_adel_o       (id_adel_o),
`endif
      .id_valid_o      (id_valid_o)
   );

   // One comparison: count it, and report it if the values differ.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of control inputs, advance the reference model and queue its prediction.
   task automatic applyStimulus(input logic r, input logic s, input logic f, input logic [31:0] fpc,
                                input logic b, input logic [31:0] tgt);
      expect_t e;
      @(negedge clk);
      rst = r;
      stall_i = s;
      flush_i = f;
      flush_pc_i = fpc;
      branch_taken_i = b;
      branch_target_i = tgt;
      if (r) begin
         mPc = 32'h0000_0000;
         mCe = 1'b0;
         mIdPc = 32'h0;
         mIdInst = 32'h0;
         mIdValid = 1'b0;
         mIdAdel = 1'b0;
      end else begin
         if (f) begin
            mIdPc = 32'h0;
            mIdInst = 32'h0;
            mIdValid = 1'b0;
            mIdAdel = 1'b0;
            mPc = fpc;
         end else if (s) begin
            mPc = mPc;
         end else if (!mCe) begin
            mIdPc = 32'h0;
            mIdInst = 32'h0;
            mIdValid = 1'b0;
            mIdAdel = 1'b0;
         end else begin
            mIdPc = mPc;
            mIdValid = 1'b1;
`ifdef FETCH_ALIGN_CHK_EN
            mIdAdel = (mPc % 4) != 0;
            mIdInst = mIdAdel ? 32'h0 : memWord(mPc);
`else
            mIdAdel = 1'b0;
            mIdInst = memWord(mPc);
`endif
            mPc = b ? tgt : mPc + 32'd4;
         end
         mCe = 1'b1;
      end
      e.ce = mCe;
      e.addr = mPc;
      e.idPc = mIdPc;
      e.idInst = mIdInst;
      e.idValid = mIdValid;
      e.idAdel = mIdAdel;
      expQ.push_back(e);
   endtask

   task automatic runCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   // Monitor: just after each rising edge, compare the DUT against the oldest prediction.
   always @(posedge clk) begin
      expect_t e;
      #1;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("inst_ce_o", {31'b0, inst_ce_o}, {31'b0, e.ce});
         checkOutput("inst_addr_o", inst_addr_o, e.addr);
         checkOutput("id_valid_o", {31'b0, id_valid_o}, {31'b0, e.idValid});
         checkOutput("id_pc_o", id_pc_o, e.idPc);
         checkOutput("id_inst_o", id_inst_o, e.idInst);
`ifdef FETCH_ALIGN_CHK_EN
         checkOutput("id_adel_o", {31'b0, id_adel_o}, {31'b0, e.idAdel});
`endif
      end
   end

   initial begin
      rst = 1'b1;
      stall_i = 1'b0;
      flush_i = 1'b0;
      flush_pc_i = 32'h0;
      branch_taken_i = 1'b0;
      branch_target_i = 32'h0;
      mPc = 32'h0;
      mCe = 1'b0;
      mIdPc = 32'h0;
      mIdInst = 32'h0;
      mIdValid = 1'b0;
      mIdAdel = 1'b0;

      // Reset, release and stream 0, 4, then stall with address 8 presented.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      repeat (3) runCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h40);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      runCycle();
      runCycle();

      // Branch at 0x10 to 0x20 keeps the delay slot, then flush beats stall and branch.
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
      runCycle();
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hE0, 1'b1, 32'h80);
      runCycle();
      runCycle();

      // Address wrap, then reset asserted in the middle of a stall.
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      runCycle();
      runCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100);
      repeat (3) runCycle();

`ifdef FETCH_ALIGN_CHK_EN
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h22);
      repeat (3) runCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
      repeat (2) runCycle();
`endif

      // Random control traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic r, s, f, b;
         logic [31:0] fpc, tgt;
         r = ($urandom_range(99) < 2);
         s = ($urandom_range(99) < 20);
         f = ($urandom_range(99) < 8);
         b = ($urandom_range(99) < 15);
         fpc = $urandom & 32'hFFFF_FFFC;
         tgt = $urandom & 32'hFFFF_FFFC;
`ifdef FETCH_ALIGN_CHK_EN
         if ($urandom_range(99) < 30) tgt = tgt | ($urandom & 32'h3);
`endif
         applyStimulus(r, s, f, fpc, b, tgt);
      end

      @(negedge clk);
      stall_i = 1'b1;
      @(posedge clk);
      #3;
      if (expQ.size() != 0) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
- IF stage of the 5-stage MIPS core; sits directly upstream of the instruction memory.
- Owns the PC register and drives the memory's chip-enable and byte address.
- Captures the returned word into the IF/ID pipeline register for decode.
- Handles stall, pipeline flush/redirect and taken branches/jumps with MIPS delay-slot semantics.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width in bits.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  hold PC and IF/ID (hazard from ID or later).
- flush_i  in  1  discard IF/ID contents and redirect to flush_pc_i (exception/eret).
- flush_pc_i  in  ADDR_W  redirect address for flush.
- branch_taken_i  in  1  from ID: taken branch/jump resolved this cycle.
- branch_target_i  in  ADDR_W  from ID: target of the taken branch/jump.
- inst_rdata_i  in  32  instruction word from memory; combinational w.r.t. inst_addr_o.
- inst_ce_o  out  1  memory chip-enable.
- inst_addr_o  out  ADDR_W  memory byte address (= PC).
- id_pc_o  out  ADDR_W  PC of the instruction held in IF/ID.
- id_inst_o  out  32  instruction held in IF/ID.
- id_valid_o  out  1  IF/ID holds a real instruction; 0 = bubble.

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC, ce_r<=0, id_pc_o<=0, id_inst_o<=0 (NOP), id_valid_o<=0.
- ce_r becomes 1 at the first edge with rst=0; inst_ce_o=ce_r; inst_addr_o=pc (registered, no combinational path from inputs).
- Memory read is zero-latency: inst_rdata_i is sampled at the same edge at which inst_addr_o is presented.
- Next-state priority at each edge (rst=0):
  1. flush_i: pc<=flush_pc_i; IF/ID<={0,0,valid=0}. Flush overrides stall and branch.
  2. stall_i: pc and IF/ID hold. branch_taken_i is ignored; ID holds the branch and re-asserts it after the stall.
  3. ce_r=0: pc holds; IF/ID<=bubble.
  4. Otherwise: IF/ID<={pc, inst_rdata_i, valid=1}. pc<=branch_taken_i ? branch_target_i : pc+4.
- Delay slot: the word fetched in the cycle branch_taken_i=1 (branch PC+4) is captured normally into IF/ID and is not squashed.
- PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC+4 wraps to 0.
- Only pc[1:0]=0 is produced by sequential fetch. Redirect targets are loaded verbatim (see optional feature).
- Throughput: one instruction per cycle absent stall/flush. Latency from address to IF/ID output: 1 cycle.
- Reset mid-operation: all state reinitialised at the next edge regardless of stall/flush/branch.

Optional Feature:
- Macro FETCH_ALIGN_CHK_EN.
- Defined: adds output id_adel_o (1 bit, reset 0). On a fetch with pc[1:0]!=0, IF/ID captures inst=0 (NOP), valid=1, id_adel_o=1 (address-error-on-load exception to later stages). id_adel_o=0 for all other captures, and cleared on flush/bubble.
- Not defined: no port. Misaligned PCs are fetched as-is; the memory ignores the low bits.

Decomposition:
- Shared package cpu_defs_pkg: INST_W=32, ADDR_W default, NOP_INST=32'h0000_0000, RESET_PC default, PC_STEP=4.
- One natural sub-module: if_id_reg (IF/ID register with hold/flush/bubble inputs), reusable pattern for later pipeline registers.
- PC/next-PC logic stays in the top.

Test Plan:
- Reset release: rst 1→0. Cycle 1: inst_ce_o=1, inst_addr_o=0. Next edge: id_pc_o=0, id_inst_o=32'h0000f025, id_valid_o=1. Following edge: id_pc_o=4, id_inst_o=32'h241d1000.
- Stall: assert stall_i 2 cycles while inst_addr_o=8. IF/ID holds id_pc_o=4 and inst_addr_o stays 8. After release, id_inst_o=32'h8f990148 with id_pc_o=8.
- Branch with delay slot: branch_taken_i=1, branch_target_i=32'h20 while inst_addr_o=32'h10. Next IF/ID entry has id_pc_o=32'h10 (delay slot kept). Then id_pc_o=32'h20, id_inst_o=32'h10800003.
- Flush beats stall and branch: flush_i=stall_i=branch_taken_i=1, flush_pc_i=32'hE0. Next edge: id_valid_o=0, id_inst_o=0, inst_addr_o=32'hE0. Then id_inst_o=32'h00802025.
- Wrap and reset mid-run: flush to 32'hFFFF_FFFC gives next inst_addr_o=0. Asserting rst during a stall gives id_valid_o=0, inst_ce_o=0, inst_addr_o=RESET_PC at the next edge.
- FETCH_ALIGN_CHK_EN: branch_target_i=32'h22. Resulting IF/ID has id_pc_o=32'h22, id_inst_o=0, id_adel_o=1. The next sequential entry (PC 32'h26) is flagged likewise until a redirect.
